// File: rtl/mem_arbiter.sv
// Arbitrates the fetch (IF) and load/store (LS) masters onto one RAM port, one transaction at a time.
// Optional macro ROUND_ROBIN_EN selects round-robin conflict resolution; otherwise LS has fixed priority.
package typepkg;
    localparam logic [31:0] RAM_BASE_ADDR = 32'h0000_1000;
    localparam logic [31:0] RAM_END_ADDR  = 32'h0000_2000;
endpackage

module mem_arbiter #(
    parameter logic [31:0] BASE_ADDR = typepkg::RAM_BASE_ADDR,
    parameter logic [31:0] END_ADDR  = typepkg::RAM_END_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        ls_req_valid,
    input  logic        ls_req_we,
    input  logic [1:0]  ls_req_size,
    input  logic        ls_req_uns,
    input  logic [31:0] ls_req_addr,
    input  logic [31:0] ls_req_wdata,
    output logic        ls_req_ready,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rsp_data,
    output logic        ls_rsp_err,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_re,
    output logic        bus_we,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_reg, state_next;
    logic        grant_ls_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rsp_data_reg;
    logic        we_reg, uns_reg, fault_reg;
    logic [1:0]  size_reg;

    logic        any_req, pick_ls;
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic        sel_fault;
    logic [3:0]  wstrb;
    logic [31:0] lane_wdata;
    logic [31:0] shifted, load_data;

    assign any_req = if_req_valid | ls_req_valid;

`ifdef ROUND_ROBIN_EN
    logic last_ls_reg;

    // Conflict goes to whichever master was not granted last; starts as "IF was last".
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_ls_reg <= 1'b0;
        else if (state_reg == IDLE && any_req)
            last_ls_reg <= pick_ls;
    end

    assign pick_ls = ls_req_valid & (~if_req_valid | ~last_ls_reg);
`else
    assign pick_ls = ls_req_valid;
`endif

    // Fetches behave as word reads.
    assign sel_addr  = pick_ls ? ls_req_addr : if_req_addr;
    assign sel_size  = pick_ls ? ls_req_size : 2'b10;
    assign sel_fault = (sel_addr < BASE_ADDR) || (sel_addr >= END_ADDR) ||
                       (sel_size == 2'b11) ||
                       (sel_size == 2'b01 && sel_addr[0]) ||
                       (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);

    always_comb begin
        case (size_reg)
            2'b00:   wstrb = 4'b0001 << addr_reg[1:0];
            2'b01:   wstrb = addr_reg[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_wdata[gi*8 +: 8] = (size_reg == 2'b00) ? wdata_reg[7:0] :
                                           (size_reg == 2'b01) ? wdata_reg[(gi%2)*8 +: 8] :
                                                                 wdata_reg[gi*8 +: 8];
        end
    endgenerate

    assign shifted = bus_rdata >> {addr_reg[1:0], 3'b000};

    always_comb begin
        load_data = shifted;
        if (fault_reg || we_reg)
            load_data = 32'h0;
        else if (!grant_ls_reg)
            load_data = bus_rdata;
        else if (size_reg == 2'b00)
            load_data = {{24{~uns_reg & shifted[7]}}, shifted[7:0]};
        else if (size_reg == 2'b01)
            load_data = {{16{~uns_reg & shifted[15]}}, shifted[15:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_ls_reg <= 1'b0;
            addr_reg     <= 32'h0;
            wdata_reg    <= 32'h0;
            we_reg       <= 1'b0;
            uns_reg      <= 1'b0;
            size_reg     <= 2'b00;
            fault_reg    <= 1'b0;
            rsp_data_reg <= 32'h0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && any_req) begin
                grant_ls_reg <= pick_ls;
                addr_reg     <= sel_addr;
                wdata_reg    <= ls_req_wdata;
                we_reg       <= pick_ls & ls_req_we;
                uns_reg      <= pick_ls & ls_req_uns;
                size_reg     <= sel_size;
                fault_reg    <= sel_fault;
            end
            if (state_reg == ACCESS)
                rsp_data_reg <= load_data;
        end
    end

    assign if_req_ready = (state_reg == IDLE);
    assign ls_req_ready = (state_reg == IDLE);

    // Bus strobes are decoded from state so an async reset drops them at once.
    always_comb begin
        state_next   = state_reg;
        bus_addr     = 32'h0;
        bus_wdata    = 32'h0;
        bus_re       = 1'b0;
        bus_we       = 1'b0;
        bus_wstrb    = 4'b0000;
        if_rsp_valid = 1'b0;
        if_rsp_data  = 32'h0;
        if_rsp_err   = 1'b0;
        ls_rsp_valid = 1'b0;
        ls_rsp_data  = 32'h0;
        ls_rsp_err   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req)
                    state_next = ACCESS;
            end
            ACCESS: begin
                state_next = RESP;
                if (!fault_reg) begin
                    bus_addr = {addr_reg[31:2], 2'b00};
                    if (we_reg) begin
                        bus_we    = 1'b1;
                        bus_wstrb = wstrb;
                        bus_wdata = lane_wdata;
                    end else begin
                        bus_re = 1'b1;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
                if (grant_ls_reg) begin
                    ls_rsp_valid = 1'b1;
                    ls_rsp_data  = rsp_data_reg;
                    ls_rsp_err   = fault_reg;
                end else begin
                    if_rsp_valid = 1'b1;
                    if_rsp_data  = rsp_data_reg;
                    if_rsp_err   = fault_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
